// File: rtl/tpu_pkg.sv
// tpu_pkg: shared defaults, offset width and FSM encoding for the TPU tile engine.
package tpu_pkg;
    localparam int ARRAY_SIZE_DEF = 4;
    localparam int DATA_W_DEF     = 8;
    localparam int ACC_W_DEF      = 32;
    localparam int K_W_DEF        = 9;
    localparam int OFF_W          = 9;

    typedef enum logic [1:0] {IDLE, FEED, WRITE, FIN} state_e;
endpackage

// File: rtl/tpu_pe.sv
// tpu_pe: systolic MAC cell; forwards A right and B down, accumulates (a+offset)*b.
module tpu_pe
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);
    localparam int SUM_W  = DATA_W + 2;
    localparam int PROD_W = SUM_W + DATA_W;

    logic signed [SUM_W-1:0]  sum;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        a_q, b_q;
    logic [ACC_W-1:0]         acc_q, acc_d;

    assign sum   = $signed({{2{a_i[DATA_W-1]}}, a_i}) +
                   $signed({{(SUM_W-OFF_W){offset_i[OFF_W-1]}}, offset_i});
    assign prod  = PROD_W'(sum) * PROD_W'($signed(b_i));
    assign acc_d = clr_i ? '0 : acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/tpu_tile_engine.sv
// tpu_tile_engine: S x S output-stationary systolic matmul tile with
// operand fetch, input skew and row-by-row result write-out.
module tpu_tile_engine
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int K_W        = K_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [K_W-1:0]               k_len,
    input  logic                         acc_en,
    input  logic [OFF_W-1:0]             offset,
    output logic                         busy,
    output logic                         done,
    output logic [K_W-1:0]               ab_index,
    input  logic [ARRAY_SIZE*DATA_W-1:0] a_data,
    input  logic [ARRAY_SIZE*DATA_W-1:0] b_data,
    output logic                         c_wr_en,
    output logic [$clog2(ARRAY_SIZE)-1:0] c_index,
    output logic [ARRAY_SIZE*ACC_W-1:0]  c_data
);
    localparam int S     = ARRAY_SIZE;
    localparam int IDX_W = $clog2(S);
    localparam int CNT_W = K_W + IDX_W + 2;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               accept, clr, in_valid;
    logic [CNT_W-1:0]   k_ext, feed_last;

    logic [DATA_W-1:0]  a_sk  [S];
    logic [DATA_W-1:0]  b_sk  [S];
    logic [DATA_W-1:0]  a_w   [S][S];
    logic [DATA_W-1:0]  b_w   [S][S];
    logic [ACC_W-1:0]   acc_w [S][S];

    assign accept    = start && state_q == IDLE;
    assign clr       = accept && !acc_en;
    assign k_ext     = CNT_W'(k_q);
    assign feed_last = k_ext + CNT_W'(2*S-2);
    // Read data returns one cycle after its index, hence the 1..k window.
    assign in_valid  = state_q == FEED && cnt_q != '0 && cnt_q <= k_ext;
    assign busy      = start || state_q != IDLE;
    assign done      = state_q == FIN;
    assign ab_index  = (state_q == FEED && cnt_q < k_ext) ? cnt_q[K_W-1:0] : '0;
    assign c_wr_en   = state_q == WRITE;
    assign c_index   = c_wr_en ? cnt_q[IDX_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        off_d   = off_q;
        case (state_q)
            IDLE: if (accept) begin
                k_d     = k_len;
                off_d   = offset;
                cnt_d   = '0;
                state_d = (k_len == '0) ? WRITE : FEED;
            end
            FEED: begin
                cnt_d   = (cnt_q == feed_last) ? '0 : cnt_q + CNT_W'(1);
                state_d = (cnt_q == feed_last) ? WRITE : FEED;
            end
            WRITE: begin
                cnt_d   = (cnt_q == CNT_W'(S-1)) ? '0 : cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(S-1)) ? FIN : WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_data = '0;
        for (int j = 0; j < S; j++)
            c_data[j*ACC_W +: ACC_W] = c_wr_en ? acc_w[c_index][j] : '0;
    end

    // Lane i of A and B is delayed i cycles so matching k indices meet in the grid.
    for (genvar i = 0; i < S; i++) begin : g_skew
        logic [DATA_W-1:0] a_in, b_in;
        assign a_in = in_valid ? a_data[i*DATA_W +: DATA_W] : '0;
        assign b_in = in_valid ? b_data[i*DATA_W +: DATA_W] : '0;
        if (i == 0) begin : g_direct
            assign a_sk[i] = a_in;
            assign b_sk[i] = b_in;
        end else begin : g_delay
            logic [DATA_W-1:0] ad_q [i];
            logic [DATA_W-1:0] bd_q [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < i; j++) begin
                        ad_q[j] <= '0;
                        bd_q[j] <= '0;
                    end
                end else begin
                    ad_q[0] <= a_in;
                    bd_q[0] <= b_in;
                    for (int j = 1; j < i; j++) begin
                        ad_q[j] <= ad_q[j-1];
                        bd_q[j] <= bd_q[j-1];
                    end
                end
            end
            assign a_sk[i] = ad_q[i-1];
            assign b_sk[i] = bd_q[i-1];
        end
    end

    for (genvar r = 0; r < S; r++) begin : g_row
        for (genvar c = 0; c < S; c++) begin : g_col
            logic [DATA_W-1:0] a_pi, b_pi;
            if (c == 0) begin : g_a_edge
                assign a_pi = a_sk[r];
            end else begin : g_a_int
                assign a_pi = a_w[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_pi = b_sk[c];
            end else begin : g_b_int
                assign b_pi = b_w[r-1][c];
            end
            tpu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr_i    (clr),
                .offset_i (off_q),
                .a_i      (a_pi),
                .b_i      (b_pi),
                .a_o      (a_w[r][c]),
                .b_o      (b_w[r][c]),
                .acc_o    (acc_w[r][c])
            );
        end
    end
endmodule

// File: tb/tb_tpu_tile_engine.sv
// tb_tpu_tile_engine: directed cycle-exact bench for the 4x4 tile engine.
module tb_tpu_tile_engine;
    import tpu_pkg::*;

    localparam logic [31:0] JUNK = 32'hA5C37E19;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         acc_en = 1'b0;
    logic [8:0]   k_len = '0;
    logic [8:0]   offset = '0;
    logic [31:0]  a_data = '0;
    logic [31:0]  b_data = '0;
    logic         busy, done, c_wr_en;
    logic [8:0]   ab_index;
    logic [1:0]   c_index;
    logic [127:0] c_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tpu_tile_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .k_len    (k_len),
        .acc_en   (acc_en),
        .offset   (offset),
        .busy     (busy),
        .done     (done),
        .ab_index (ab_index),
        .a_data   (a_data),
        .b_data   (b_data),
        .c_wr_en  (c_wr_en),
        .c_index  (c_index),
        .c_data   (c_data)
    );

    // One run starting now (start cycle = n 0); expected C[i][j] = e, or e*(i+1)*(j+1) when ij.
    task automatic run(input int k, input logic ae, input logic [8:0] off,
                       input logic [31:0] aw, input logic [31:0] bw,
                       input int e, input bit ij, input bit poke);
        int ws, row;
        logic wr;
        logic [8:0] exp_ab;
        logic [127:0] er;
        ws = (k == 0) ? 1 : k + 8;
        start = 1'b1; k_len = 9'(k); acc_en = ae; offset = off;
        a_data = JUNK; b_data = JUNK;
        for (int n = 0; n <= ws + 4; n++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL busy k=%0d n=%0d: got %b want 1", k, n, busy);
            end
            exp_ab = (n >= 1 && n <= k) ? 9'(n - 1) : 9'd0;
            checks++;
            if (ab_index !== exp_ab) begin
                errors++; $display("FAIL ab_index k=%0d n=%0d: got %0d want %0d", k, n, ab_index, exp_ab);
            end
            wr = (n >= ws && n < ws + 4);
            row = n - ws;
            er = '0;
            if (wr)
                for (int j = 0; j < 4; j++)
                    er[j*32 +: 32] = ij ? 32'(e * (row + 1) * (j + 1)) : 32'(e);
            checks++;
            if (c_wr_en !== wr) begin
                errors++; $display("FAIL c_wr_en k=%0d n=%0d: got %b want %b", k, n, c_wr_en, wr);
            end
            checks++;
            if (c_index !== (wr ? 2'(row) : 2'd0)) begin
                errors++; $display("FAIL c_index k=%0d n=%0d: got %0d want %0d", k, n, c_index, wr ? row : 0);
            end
            checks++;
            if (c_data !== er) begin
                errors++; $display("FAIL c_data k=%0d n=%0d: got %h want %h", k, n, c_data, er);
            end
            checks++;
            if (done !== (n == ws + 4)) begin
                errors++; $display("FAIL done k=%0d n=%0d: got %b want %b", k, n, done, n == ws + 4);
            end
            @(posedge clk); #1;
            start = poke && n == 2;
            if (poke && n == 2) begin
                k_len = 9'd1; acc_en = 1'b0; offset = 9'd50;
            end
            a_data = (n + 1 >= 2 && n + 1 <= k + 1) ? aw : JUNK;
            b_data = (n + 1 >= 2 && n + 1 <= k + 1) ? bw : JUNK;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        start = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, c_wr_en, ab_index, c_index, c_data} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %b/%b/%b/%0d/%0d/%h want all 0",
                                busy, done, c_wr_en, ab_index, c_index, c_data);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_single;
        run(1, 1'b0, 9'd0, 32'h01010101, 32'h02020202, 2, 1'b0, 1'b0);
    endtask

    task automatic test_offset;
        run(3, 1'b0, 9'd128, 32'h80808080, 32'h05050505, 0, 1'b0, 1'b0);
    endtask

    task automatic test_long;
        run(256, 1'b0, 9'd0, 32'h7f7f7f7f, 32'h7f7f7f7f, 4129024, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run(2, 1'b0, 9'd0, 32'h01010101, 32'h03030303, 6, 1'b0, 1'b0);
        run(2, 1'b1, 9'd0, 32'h01010101, 32'h03030303, 12, 1'b0, 1'b0);
        run(0, 1'b0, 9'd0, 32'h01010101, 32'h03030303, 0, 1'b0, 1'b0);
    endtask

    task automatic test_distinct;
        run(4, 1'b0, 9'd0, 32'h04030201, 32'h04030201, 4, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid;
        start = 1'b1; k_len = 9'd1; acc_en = 1'b0; offset = 9'd0;
        a_data = 32'h01010101; b_data = 32'h02020202;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, c_wr_en, ab_index, c_index, c_data} !== '0) begin
            errors++; $display("FAIL midrun_reset_outputs: got %b/%b/%b/%0d/%0d/%h want all 0",
                                busy, done, c_wr_en, ab_index, c_index, c_data);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++; $display("FAIL midrun_reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run(1, 1'b1, 9'd0, 32'h01010101, 32'h02020202, 2, 1'b0, 1'b0);
    endtask

    task automatic test_idle;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || c_wr_en !== 1'b0) begin
                errors++; $display("FAIL idle: got busy=%b done=%b wr=%b want 0 0 0", busy, done, c_wr_en);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_offset;
        test_long;
        test_back_to_back;
        test_distinct;
        test_reset_mid;
        test_idle;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
